decode_lane_compactor: RTL and testbench

- Parametrised buffering stage between decode and the decode→rename FIFO.
- Accepts up to IN_WIDTH decoded packs per cycle under a sparse valid mask and compacts them, preserving lane order, into a circular queue.
- Emits up to OUT_WIDTH contiguous packs per cycle into the rename FIFO according to its per-slot enable mask.
- Supports commit flush, idle feedback and a rename-full stall indication.

---
 rtl/decode_lane_compactor.sv | 171 +++++++++++++++++
 tb/tb_decode_lane_compactor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_lane_compactor.sv
// decode_lane_compactor
//   Buffering stage between decode and the decode->rename FIFO. Up to IN_WIDTH
//   decoded packs arrive per cycle under a sparse valid mask; they are compacted
//   in lane order into a DEPTH-entry circular queue. Up to OUT_WIDTH contiguous
//   packs leave per cycle, limited by the leading run of ones in i_out_enable.
//   Acceptance is all-or-nothing and may reuse slots freed by this cycle's
//   output.
//
// Optional feature (macro DECODE_LANE_COMPACTOR_BYPASS_EN):
//   When the queue is empty, compacted input lanes drive the outputs in the
//   same cycle. Only the remainder that is not bypassed is enqueued.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_in_data         IN_WIDTH packs, lane i at [i*PACK_WIDTH +: PACK_WIDTH]
//   i_in_valid        sparse lane valid mask
//   o_in_pop_valid    lanes consumed this cycle
//   o_in_pop          whole group accepted this cycle
//   i_out_enable      rename FIFO free-slot mask (leading ones only)
//   o_out_data        packs to rename FIFO, oldest in lane 0
//   o_out_valid       contiguous valid mask from lane 0
//   o_out_push        |o_out_valid
//   i_flush           commit-stage flush
//   o_idle            queue empty
//   o_full_add        stall-cycle event (data held, no free rename slot)
//   o_count           current occupancy
//
// DEPTH must be a power of two, at least 2, and >= max(IN_WIDTH, OUT_WIDTH).
module decode_lane_compactor #(
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned OUT_WIDTH  = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PACK_WIDTH = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [IN_WIDTH*PACK_WIDTH-1:0]  i_in_data,
    input  logic [IN_WIDTH-1:0]             i_in_valid,
    output logic [IN_WIDTH-1:0]             o_in_pop_valid,
    output logic                            o_in_pop,
    input  logic [OUT_WIDTH-1:0]            i_out_enable,
    output logic [OUT_WIDTH*PACK_WIDTH-1:0] o_out_data,
    output logic [OUT_WIDTH-1:0]            o_out_valid,
    output logic                            o_out_push,
    input  logic                            i_flush,
    output logic                            o_idle,
    output logic                            o_full_add,
    output logic [$clog2(DEPTH+1)-1:0]      o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PACK_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [CW-1:0]         r_count;

    logic                  w_kill;
    logic                  w_run;
    logic                  w_accept;
    logic [CW-1:0]         w_n_in;
    logic [CW-1:0]         w_n_run;
    logic [CW-1:0]         w_n_out;
    logic [CW-1:0]         w_n_byp;
    logic [CW-1:0]         w_n_enq;
    logic [CW-1:0]         w_n_vis;
    logic [CW-1:0]         w_k;
    logic [IN_WIDTH-1:0]   w_wr_en;
    logic [PW-1:0]         w_wr_idx [IN_WIDTH];

    // Occupancy arithmetic: n_in, leading-ones run, drain count and acceptance.
    always_comb begin
        w_kill = i_rst | i_flush;
        w_n_in = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_n_in = w_n_in + CW'(i_in_valid[i]);
        end
        w_n_run = '0;
        w_run   = 1'b1;
        for (int j = 0; j < OUT_WIDTH; j++) begin
            w_run   = w_run & i_out_enable[j];
            w_n_run = w_n_run + CW'(w_run);
        end
        w_n_out  = w_kill ? '0 : ((r_count < w_n_run) ? r_count : w_n_run);
        // DEPTH - count + n_out never exceeds DEPTH since n_out <= count.
        w_accept = !w_kill && (w_n_in <= (DEPTH_C - r_count + w_n_out));
    end

`ifdef DECODE_LANE_COMPACTOR_BYPASS_EN
    logic                  w_byp_on;
    logic [PACK_WIDTH-1:0] w_cmp [OUT_WIDTH];

    always_comb begin
        w_byp_on = !w_kill && (r_count == '0);
        w_n_byp  = w_byp_on ? ((w_n_in < w_n_run) ? w_n_in : w_n_run) : '0;
        for (int j = 0; j < OUT_WIDTH; j++) begin
            w_cmp[j] = '0;
        end
        begin
            int k;
            k = 0;
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (i_in_valid[i]) begin
                    if (k < int'(OUT_WIDTH)) begin
                        w_cmp[k] = i_in_data[i*PACK_WIDTH +: PACK_WIDTH];
                    end
                    k = k + 1;
                end
            end
        end
    end
`else
    assign w_n_byp = '0;
`endif

    // Write slot per lane: the k-th valid lane goes to wptr + k, skipping any
    // lanes that were bypassed straight to the output.
    always_comb begin
        w_n_enq = w_accept ? (w_n_in - w_n_byp) : '0;
        w_n_vis = w_n_out + w_n_byp;
        w_k     = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_wr_en[i]  = w_accept & i_in_valid[i] & (w_k >= w_n_byp);
            w_wr_idx[i] = r_wptr + PW'(w_k - w_n_byp);
            w_k         = w_k + CW'(i_in_valid[i]);
        end
    end

    always_comb begin
        o_out_data = '0;
        for (int j = 0; j < OUT_WIDTH; j++) begin
            o_out_valid[j] = (CW'(j) < w_n_vis);
`ifdef DECODE_LANE_COMPACTOR_BYPASS_EN
            o_out_data[j*PACK_WIDTH +: PACK_WIDTH] =
                w_byp_on ? w_cmp[j] : r_mem[r_rptr + PW'(j)];
`else
            o_out_data[j*PACK_WIDTH +: PACK_WIDTH] = r_mem[r_rptr + PW'(j)];
`endif
        end
        o_out_push     = |o_out_valid;
        o_in_pop       = w_accept;
        o_in_pop_valid = w_accept ? i_in_valid : '0;
        o_full_add     = !w_kill && (r_count != '0) && (w_n_run == '0);
        o_idle         = (r_count == '0);
        o_count        = r_count;
    end

    always_ff @(posedge i_clk) begin
        if (w_kill) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_n_enq);
            r_rptr  <= r_rptr + PW'(w_n_out);
            r_count <= r_count + w_n_enq - w_n_out;
        end
    end

    // Storage is never cleared; occupancy alone defines what is live.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_idx[i]] <= i_in_data[i*PACK_WIDTH +: PACK_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_decode_lane_compactor.sv
// tb_decode_lane_compactor
//   Directed, table-driven bench for decode_lane_compactor (default build,
//   IN_WIDTH=OUT_WIDTH=4, DEPTH=8, PACK_WIDTH=64). Each table row is one clock
//   cycle: inputs are driven just after the rising edge and outputs are checked
//   on the falling edge. Lane i of a row carries {8{base+i}}.
module tb_decode_lane_compactor;

    logic         clk;
    logic         rst;
    logic [255:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_pop_valid;
    logic         in_pop;
    logic [3:0]   out_enable;
    logic [255:0] out_data;
    logic [3:0]   out_valid;
    logic         out_push;
    logic         flush;
    logic         idle;
    logic         full_add;
    logic [3:0]   count;

    int n_checks;
    int n_errors;

    decode_lane_compactor #(
        .IN_WIDTH   (4),
        .OUT_WIDTH  (4),
        .DEPTH      (8),
        .PACK_WIDTH (64)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_data      (in_data),
        .i_in_valid     (in_valid),
        .o_in_pop_valid (in_pop_valid),
        .o_in_pop       (in_pop),
        .i_out_enable   (out_enable),
        .o_out_data     (out_data),
        .o_out_valid    (out_valid),
        .o_out_push     (out_push),
        .i_flush        (flush),
        .o_idle         (idle),
        .o_full_add     (full_add),
        .o_count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic [3:0] iv;
        logic [3:0] oe;
        logic [7:0] base;
        logic       pop;
        logic [3:0] popv;
        logic [3:0] ov;
        logic       fa;
        logic       idle;
        logic [3:0] cnt;
        logic [7:0] o0;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [7:0] o3;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic [3:0] iv,
                       input logic [3:0] oe, input logic [7:0] base,
                       input logic pop, input logic [3:0] popv, input logic [3:0] ov,
                       input logic fa, input logic idl, input logic [3:0] cnt,
                       input logic [7:0] o0, input logic [7:0] o1,
                       input logic [7:0] o2, input logic [7:0] o3);
        vec_t v;
        v = '{rst: r, flush: f, iv: iv, oe: oe, base: base, pop: pop, popv: popv,
              ov: ov, fa: fa, idle: idl, cnt: cnt, o0: o0, o1: o1, o2: o2, o3: o3};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst   = v.rst;
        flush = v.flush;
        in_valid   = v.iv;
        out_enable = v.oe;
        for (int i = 0; i < 4; i++) begin
            in_data[i*64 +: 64] = {8{v.base + 8'(i)}};
        end
    endtask

    initial begin
        logic [7:0] eo [4];
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        out_enable = '0;
        in_data = '0;

        // Hand-written reset sequence: one cycle of rst, then idle state.
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset idle", -1, 64'(idle), 64'd1);
        chk("reset count", -1, 64'(count), 64'd0);
        chk("reset out_valid", -1, 64'(out_valid), 64'd0);
        chk("reset out_push", -1, 64'(out_push), 64'd0);
        chk("reset full_add", -1, 64'(full_add), 64'd0);
        chk("reset in_pop", -1, 64'(in_pop), 64'd1);

        //  rst fl  iv       oe       base   pop popv     ov       fa idl cnt  o0..o3
        add(0, 0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        // Sparse compaction: A at lane 1, B at lane 3.
        add(0, 0, 4'b1010, 4'b0000, 8'hA0, 1, 4'b1010, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 4'b0000, 1, 0, 2, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b0011, 0, 0, 2,
            8'hA1, 8'hA3, 0, 0);
        add(0, 0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        // Backpressure to full, then refused groups.
        add(0, 0, 4'b1111, 4'b0000, 8'hB0, 1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 4'b1111, 4'b0000, 8'hC0, 1, 4'b1111, 4'b0000, 1, 0, 4, 0, 0, 0, 0);
        add(0, 0, 4'b1111, 4'b0000, 8'hD0, 0, 4'b0000, 4'b0000, 1, 0, 8, 0, 0, 0, 0);
        add(0, 0, 4'b1111, 4'b0000, 8'hD0, 0, 4'b0000, 4'b0000, 1, 0, 8, 0, 0, 0, 0);
        // Partial drain of 3 with reuse of the freed slots.
        add(0, 0, 4'b0011, 4'b0111, 8'hE0, 1, 4'b0011, 4'b0111, 0, 0, 8,
            8'hB0, 8'hB1, 8'hB2, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b1111, 0, 0, 7,
            8'hB3, 8'hC0, 8'hC1, 8'hC2);
        add(0, 0, 4'b1111, 4'b1111, 8'hF0, 1, 4'b1111, 4'b0111, 0, 0, 3,
            8'hC3, 8'hE0, 8'hE1, 0);
        // Leading-ones run of out_enable.
        add(0, 0, 4'b0000, 4'b0001, 8'h00, 1, 4'b0000, 4'b0001, 0, 0, 4, 8'hF0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b1011, 8'h00, 1, 4'b0000, 4'b0011, 0, 0, 3,
            8'hF1, 8'hF2, 0, 0);
        add(0, 0, 4'b0000, 4'b1110, 8'h00, 1, 4'b0000, 4'b0000, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b0001, 0, 0, 1, 8'hF3, 0, 0, 0);
        // Flush with 5 entries held and a group offered.
        add(0, 0, 4'b1111, 4'b0000, 8'h30, 1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 4'b0000, 8'h40, 1, 4'b0001, 4'b0000, 1, 0, 4, 0, 0, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 8'h50, 0, 4'b0000, 4'b0000, 0, 0, 5, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        // Same with reset mid-stream.
        add(0, 0, 4'b1111, 4'b0000, 8'h60, 1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 4'b0000, 8'h70, 1, 4'b0001, 4'b0000, 1, 0, 4, 0, 0, 0, 0);
        add(1, 0, 4'b1111, 4'b1111, 8'h50, 0, 4'b0000, 4'b0000, 0, 0, 5, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        // Wrap: push 6, drain 6, push tags 0..3 into entries 6,7,0,1.
        add(0, 0, 4'b1111, 4'b0000, 8'h80, 1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0011, 4'b0000, 8'h84, 1, 4'b0011, 4'b0000, 1, 0, 4, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b1111, 0, 0, 6,
            8'h80, 8'h81, 8'h82, 8'h83);
        add(0, 0, 4'b1111, 4'b1111, 8'h00, 1, 4'b1111, 4'b0011, 0, 0, 2,
            8'h84, 8'h85, 0, 0);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b1111, 0, 0, 4,
            8'h00, 8'h01, 8'h02, 8'h03);
        // Full queue: full drain and full refill in the same cycle.
        add(0, 0, 4'b1111, 4'b0000, 8'h90, 1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 4'b1111, 4'b0000, 8'h94, 1, 4'b1111, 4'b0000, 1, 0, 4, 0, 0, 0, 0);
        add(0, 0, 4'b1111, 4'b1111, 8'h98, 1, 4'b1111, 4'b1111, 0, 0, 8,
            8'h90, 8'h91, 8'h92, 8'h93);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b1111, 0, 0, 8,
            8'h94, 8'h95, 8'h96, 8'h97);
        add(0, 0, 4'b0000, 4'b1111, 8'h00, 1, 4'b0000, 4'b1111, 0, 0, 4,
            8'h98, 8'h99, 8'h9A, 8'h9B);
        add(0, 0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clk);
            #1 drive(vecs[r]);
            @(negedge clk);
            chk("in_pop", r, 64'(in_pop), 64'(vecs[r].pop));
            chk("in_pop_valid", r, 64'(in_pop_valid), 64'(vecs[r].popv));
            chk("out_valid", r, 64'(out_valid), 64'(vecs[r].ov));
            chk("out_push", r, 64'(out_push), 64'(|vecs[r].ov));
            chk("full_add", r, 64'(full_add), 64'(vecs[r].fa));
            chk("idle", r, 64'(idle), 64'(vecs[r].idle));
            chk("count", r, 64'(count), 64'(vecs[r].cnt));
            eo[0] = vecs[r].o0;
            eo[1] = vecs[r].o1;
            eo[2] = vecs[r].o2;
            eo[3] = vecs[r].o3;
            for (int j = 0; j < 4; j++) begin
                if (vecs[r].ov[j]) begin
                    chk($sformatf("out_data lane%0d", j), r, out_data[j*64 +: 64],
                        {8{eo[j]}});
                end
            end
        end

        // Hand-written tail: an empty queue ignores out_enable and accepts a
        // group, which appears one cycle later.
        @(posedge clk);
        #1;
        in_valid = 4'b0100;
        out_enable = 4'b1111;
        in_data[2*64 +: 64] = {8{8'h5A}};
        @(negedge clk);
        chk("empty out_valid", -2, 64'(out_valid), 64'd0);
        chk("empty in_pop", -2, 64'(in_pop), 64'd1);
        @(posedge clk);
        #1 in_valid = 4'b0000;
        @(negedge clk);
        chk("latency out_valid", -2, 64'(out_valid), 64'd1);
        chk("latency lane0", -2, out_data[63:0], {8{8'h5A}});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drained idle", -2, 64'(idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
